// File: rtl/uart_bus_master_pkg.sv
// Shared opcode/reply bytes and FSM state encoding for the UART-driven bus master.
package uart_bus_master_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_REQ  = 3'd3,
    S_XFER = 3'd4,
    S_WAIT = 3'd5,
    S_RESP = 3'd6
  } state_t;

endpackage

// File: rtl/uart_bus_master.sv
// Decodes 'W'/'R' host frames from a UART byte stream and runs one word transaction
// on the SoC bus per frame, replying 'K', four read-data bytes, or '?'.
//
// state  | meaning
// IDLE   | waiting for a command byte
// ADDR   | shifting in 4 address bytes (big-endian)
// DATA   | shifting in 4 write-data bytes (write only)
// REQ    | bus_req high, waiting for bus_grant
// XFER   | single-cycle writeenable/readenable strobe
// WAIT   | read latency countdown, readdata captured on last cycle
// RESP   | handing reply bytes to the UART transmitter
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [29:0] address,
  output logic [31:0] writedata,
  output logic        writeenable,
  output logic        readenable,
  output logic [3:0]  byteena,
  input  logic [31:0] readdata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [2:0]    LAT_LOAD = 3'(READ_LATENCY - 1);

  state_t        state_q;
  logic          is_write_q;
  logic [1:0]    byte_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [2:0]    lat_cnt_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [31:0]   resp_q;
  logic [1:0]    resp_left_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          bus_req_q;
  logic          we_q;
  logic          re_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      is_write_q  <= 1'b0;
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
      lat_cnt_q   <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      bus_req_q   <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            byte_cnt_q <= '0;
            to_cnt_q   <= TO_LOAD;
            if (rx_data == OP_WRITE || rx_data == OP_READ) begin
              is_write_q <= (rx_data == OP_WRITE);
              state_q    <= S_ADDR;
            end else begin
              tx_data_q   <= RSP_ERR;
              tx_valid_q  <= 1'b1;
              resp_left_q <= 2'd0;
              state_q     <= S_RESP;
            end
          end
        end

        S_ADDR, S_DATA: begin
          if (rx_valid) begin
            to_cnt_q   <= TO_LOAD;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (state_q == S_ADDR) addr_q <= {addr_q[23:0], rx_data};
            else                   data_q <= {data_q[23:0], rx_data};
            if (byte_cnt_q == 2'd3) begin
              if (state_q == S_ADDR && is_write_q) begin
                state_q <= S_DATA;
              end else begin
                state_q   <= S_REQ;
                bus_req_q <= 1'b1;
              end
            end
          end else if (to_cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q - 1'b1;
          end
        end

        S_REQ: begin
          if (bus_grant) begin
            we_q    <= is_write_q;
            re_q    <= !is_write_q;
            state_q <= S_XFER;
          end
        end

        S_XFER: begin
          we_q <= 1'b0;
          re_q <= 1'b0;
          if (is_write_q) begin
            bus_req_q   <= 1'b0;
            tx_data_q   <= RSP_ACK;
            tx_valid_q  <= 1'b1;
            resp_left_q <= 2'd0;
            state_q     <= S_RESP;
          end else begin
            lat_cnt_q <= LAT_LOAD;
            state_q   <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (lat_cnt_q == 3'd0) begin
            bus_req_q   <= 1'b0;
            resp_q      <= readdata;
            tx_data_q   <= readdata[31:24];
            tx_valid_q  <= 1'b1;
            resp_left_q <= 2'd3;
            state_q     <= S_RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - 3'd1;
          end
        end

        S_RESP: begin
          if (tx_ready) begin
            if (resp_left_q == 2'd0) begin
              tx_valid_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              // resp_q[31:24] is the byte just accepted; the next one sits below it
              tx_data_q   <= resp_q[23:16];
              resp_q      <= {resp_q[23:0], 8'h00};
              resp_left_q <= resp_left_q - 2'd1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Byte-address bits [1:0] carry no meaning on a word bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_q[1:0];

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign bus_req     = bus_req_q;
  assign address     = addr_q[31:2];
  assign writedata   = data_q;
  assign writeenable = we_q;
  assign readenable  = re_q;
  assign byteena     = 4'hF;

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: stimulus queues expected bus cycles and reply
// bytes, negedge monitors pop and compare whenever the DUT strobes or hands over a byte.
module tb_uart_bus_master;

  localparam int RL = 3;
  localparam int TO = 40;

  typedef struct {
    bit          w;
    logic [29:0] a;
    logic [31:0] d;
  } bus_t;
  typedef logic [7:0] frame_t[$];

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_req;
  logic        bus_grant;
  logic [29:0] address;
  logic [31:0] writedata;
  logic        writeenable;
  logic        readenable;
  logic [3:0]  byteena;
  logic [31:0] readdata;

  int tot = 0;
  int bad = 0;

  logic [7:0] exp_tx[$];
  bus_t       exp_bus[$];
  logic [31:0] rd_val;
  int          req_cycles = 0;

  uart_bus_master #(.READ_LATENCY(RL), .TIMEOUT(TO)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_req(bus_req), .bus_grant(bus_grant),
    .address(address), .writedata(writedata),
    .writeenable(writeenable), .readenable(readenable),
    .byteena(byteena), .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Arbiter: grants 2 cycles after request, drops grant with the request.
  initial begin
    int cnt = 0;
    bus_grant = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!bus_req) begin
        bus_grant = 1'b0;
        cnt = 0;
      end else if (cnt >= 2) begin
        bus_grant = 1'b1;
      end else begin
        cnt++;
      end
    end
  end

  // Memory model: readdata valid only RL cycles after readenable, junk otherwise.
  logic       re_seen = 1'b0;
  logic [7:0] re_hist = '0;
  initial begin
    readdata = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk); #1;
      re_hist = {re_hist[6:0], re_seen};
      readdata = re_hist[RL-1] ? rd_val : (32'hBAD0_BAD0 ^ {24'h0, re_hist});
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       we_prev = 1'b0;
    forever begin
      @(negedge clk);
      re_seen = readenable;
      if (!reset_n) begin
        prev_stall = 1'b0;
        we_prev = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("tx_hold_valid", 32'(tx_valid), 32'd1);
          chk("tx_hold_data", 32'(tx_data), 32'(prev_data));
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) begin
            tot++; bad++;
            $display("FAIL tx_unexpected act=%0h exp=none", tx_data);
          end else begin
            chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
          end
        end
        if (we_prev) chk("wr_req_drop", 32'(bus_req), 32'd0);
        we_prev = writeenable;
        if (writeenable || readenable) begin
          if (exp_bus.size() == 0) begin
            tot++; bad++;
            $display("FAIL bus_unexpected act=we%0b re%0b exp=none", writeenable, readenable);
          end else begin
            bus_t b;
            b = exp_bus.pop_front();
            chk("strobe_kind", 32'({writeenable, readenable}), b.w ? 32'd2 : 32'd1);
            chk("bus_addr", 32'(address), 32'(b.a));
            if (b.w) chk("bus_wdata", writedata, b.d);
            chk("bus_grant_at_strobe", 32'(bus_grant), 32'd1);
            chk("byteena", 32'(byteena), 32'hF);
          end
        end
        if (bus_req) req_cycles++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < 300) begin
      @(posedge clk); n++;
    end
    chk(name, 32'(exp_tx.size() + exp_bus.size()), 32'd0);
    exp_tx.delete();
    exp_bus.delete();
    repeat (4) @(posedge clk);
  endtask

  task automatic push_read(input logic [29:0] a, input logic [31:0] d);
    bus_t b;
    b.w = 1'b0; b.a = a; b.d = '0;
    exp_bus.push_back(b);
    rd_val = d;
    exp_tx.push_back(d[31:24]); exp_tx.push_back(d[23:16]);
    exp_tx.push_back(d[15:8]);  exp_tx.push_back(d[7:0]);
  endtask

  task automatic push_write(input logic [29:0] a, input logic [31:0] d);
    bus_t b;
    b.w = 1'b1; b.a = a; b.d = d;
    exp_bus.push_back(b);
    exp_tx.push_back(8'h4B);
  endtask

  initial begin
    int snap;
    int n;
    reset_n = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b1; rd_val = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(writeenable), 32'd0);
    chk("rst_re", 32'(readenable), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_wdata", writedata, 32'd0);
    chk("rst_byteena", 32'(byteena), 32'hF);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: write frame
    push_write(30'h0000401, 32'hDEADBEEF);
    send_frame('{8'h57, 8'h00, 8'h00, 8'h10, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
    wait_drain("t1_write_drain");

    // 2: read frame
    push_read(30'h2, 32'h12345678);
    send_frame('{8'h52, 8'h00, 8'h00, 8'h00, 8'h08});
    wait_drain("t2_read_drain");

    // 3: unknown command, then a normal read
    snap = req_cycles;
    exp_tx.push_back(8'h3F);
    send_byte(8'h41);
    wait_drain("t3_unknown_drain");
    chk("t3_no_bus_req", 32'(req_cycles), 32'(snap));
    push_read(30'h40, 32'hCAFEF00D);
    send_frame('{8'h52, 8'h00, 8'h00, 8'h01, 8'h00});
    wait_drain("t3_read_drain");

    // 4: partial frame then silence past timeout; next frames start fresh
    snap = req_cycles;
    send_frame('{8'h57, 8'h00, 8'h00});
    repeat (TO + 10) @(posedge clk);
    chk("t4_timeout_no_req", 32'(req_cycles), 32'(snap));
    push_write(30'h3, 32'h01020304);
    send_frame('{8'h57, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h01, 8'h02, 8'h03, 8'h04});
    wait_drain("t4_write_drain");
    push_read(30'h5, 32'h0BADCAFE);
    send_byte(8'h52);
    repeat (TO - 4) @(posedge clk);
    send_frame('{8'h00, 8'h00, 8'h00, 8'h14});
    wait_drain("t4_slow_read_drain");

    // 5: transmitter back-pressure during read reply
    push_read(30'h7, 32'hA1B2C3D4);
    tx_ready = 1'b0;
    send_frame('{8'h52, 8'h00, 8'h00, 8'h00, 8'h1C});
    n = 0;
    while (!tx_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("t5_tx_valid_seen", 32'(tx_valid), 32'd1);
    repeat (10) @(posedge clk);
    #1 tx_ready = 1'b1;
    @(posedge clk); #1 tx_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_drain("t5_stall_drain");

    // 6: reset during WAIT
    begin
      bus_t b;
      b.w = 1'b0; b.a = 30'h8; b.d = '0;
      exp_bus.push_back(b);
    end
    rd_val = 32'h55555555;
    send_frame('{8'h52, 8'h00, 8'h00, 8'h00, 8'h20});
    n = 0;
    while (!readenable && n < 100) begin @(negedge clk); n++; end
    chk("t6_re_seen", 32'(readenable), 32'd1);
    @(posedge clk); #1;
    chk("t6_req_in_wait", 32'(bus_req), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_async_bus_req", 32'(bus_req), 32'd0);
    chk("t6_async_tx_valid", 32'(tx_valid), 32'd0);
    chk("t6_async_re", 32'(readenable), 32'd0);
    chk("t6_async_addr", 32'(address), 32'd0);
    chk("t6_async_byteena", 32'(byteena), 32'hF);
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("t6_no_reply", 32'(tx_valid), 32'd0);
    push_write(30'h10, 32'h55AA55AA);
    send_frame('{8'h57, 8'h00, 8'h00, 8'h00, 8'h40, 8'h55, 8'hAA, 8'h55, 8'hAA});
    wait_drain("t6_write_drain");

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
